// File: rtl/modclk_pkg.sv
// Shared definitions for the modulation-clock frequency-select stage.
//   - select encodings for the six supported modulation frequencies
//   - period_cycles(): USER_CLOCK cycles per modulation period
//   - FSM state type and the period counter width
package modclk_pkg;

    localparam logic [2:0] SEL_100K = 3'd0;
    localparam logic [2:0] SEL_200K = 3'd1;
    localparam logic [2:0] SEL_500K = 3'd2;
    localparam logic [2:0] SEL_1M   = 3'd3;
    localparam logic [2:0] SEL_2M   = 3'd4;
    localparam logic [2:0] SEL_4M   = 3'd5;

    typedef enum logic [0:0] {
        StRun,
        StArmed
    } state_e;

    // Elaboration-time helper; at runtime the top selects among precomputed constants.
    function automatic int unsigned period_cycles(input int unsigned clk_hz,
                                                  input logic [2:0]  sel);
        int unsigned f_hz;
        case (sel)
            SEL_100K: f_hz = 100_000;
            SEL_200K: f_hz = 200_000;
            SEL_500K: f_hz = 500_000;
            SEL_1M:   f_hz = 1_000_000;
            SEL_2M:   f_hz = 2_000_000;
            default:  f_hz = 4_000_000;
        endcase
        return clk_hz / f_hz;
    endfunction

    // Wide enough for the longest (100 kHz) period at 200 MHz.
    localparam int unsigned CNT_W = $clog2(period_cycles(200_000_000, SEL_100K));

endpackage

// File: rtl/modclk_freq_select_if.sv
// Pin-level bundle of the frequency-select stage.
//   FREQ_SEL       : asynchronous 3-bit select pins (driven by master)
//   FREQ_OUT       : 50 % duty modulation square wave
//   FREQ_TICK      : one-cycle pulse with each FREQ_OUT rising edge
//   FREQ_ACTIVE    : select currently applied
//   CHANGE_PENDING : accepted select waiting for the period boundary
//   SEL_INVALID    : last filtered select was 6 or 7
interface modclk_freq_select_if;

    logic [2:0] FREQ_SEL;
    logic       FREQ_OUT;
    logic       FREQ_TICK;
    logic [2:0] FREQ_ACTIVE;
    logic       CHANGE_PENDING;
    logic       SEL_INVALID;

    modport master (
        output FREQ_SEL,
        input  FREQ_OUT,
        input  FREQ_TICK,
        input  FREQ_ACTIVE,
        input  CHANGE_PENDING,
        input  SEL_INVALID
    );

    modport slave (
        input  FREQ_SEL,
        output FREQ_OUT,
        output FREQ_TICK,
        output FREQ_ACTIVE,
        output CHANGE_PENDING,
        output SEL_INVALID
    );

endinterface

// File: rtl/sel_filter.sv
// Select-pin conditioner: 2-flop synchronizer followed by a stability counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   sel_i         : raw asynchronous select pins
//   filt_valid_o  : one-cycle strobe once the synchronized value has held long enough
//   filt_sel_o    : the filtered value (meaningful while filt_valid_o is high)
module sel_filter
    import modclk_pkg::*;
#(
    parameter int unsigned StableCycles = 1024,
    parameter logic [2:0]  DefaultSel   = SEL_4M
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] sel_i,
    output logic       filt_valid_o,
    output logic [2:0] filt_sel_o
);

    // One extra count value so the counter can park after reporting.
    localparam int unsigned StabW = $clog2(StableCycles + 1);

    logic [2:0]       sync1_q, sync2_q, prev_q;
    logic [StabW-1:0] stab_q, stab_d;
    logic             changed;

    assign changed = (sync2_q != prev_q);

    always_comb begin
        stab_d = stab_q;
        if (changed) begin
            stab_d = '0;
        end else if (stab_q != StabW'(StableCycles)) begin
            stab_d = stab_q + StabW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= DefaultSel;
            sync2_q <= DefaultSel;
            prev_q  <= DefaultSel;
            stab_q  <= '0;
        end else begin
            sync1_q <= sel_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
        end
    end

    // Fires exactly once per stable run: the counter parks past StableCycles-1.
    assign filt_valid_o = !changed && (stab_q == StabW'(StableCycles - 1));
    assign filt_sel_o   = sync2_q;

endmodule

// File: rtl/modclk_freq_select.sv
// Runtime frequency-select stage feeding the non-overlap modulation clock generator.
// Filters the select pins and emits a 50 % duty square wave whose period is switched
// only at a period boundary, so no runt or stretched phase ever reaches the output.
//   USER_CLOCK : sole clock
//   RESET_N    : asynchronous active-low reset
//   freq_io    : select pins in; wave, tick and status out
module modclk_freq_select
    import modclk_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 200_000_000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter logic [2:0]  DEFAULT_SEL   = SEL_4M
) (
    input logic                 USER_CLOCK,
    input logic                 RESET_N,
    modclk_freq_select_if.slave freq_io
);

    localparam logic [CNT_W-1:0] PER_100K = CNT_W'(period_cycles(CLK_HZ, SEL_100K));
    localparam logic [CNT_W-1:0] PER_200K = CNT_W'(period_cycles(CLK_HZ, SEL_200K));
    localparam logic [CNT_W-1:0] PER_500K = CNT_W'(period_cycles(CLK_HZ, SEL_500K));
    localparam logic [CNT_W-1:0] PER_1M   = CNT_W'(period_cycles(CLK_HZ, SEL_1M));
    localparam logic [CNT_W-1:0] PER_2M   = CNT_W'(period_cycles(CLK_HZ, SEL_2M));
    localparam logic [CNT_W-1:0] PER_4M   = CNT_W'(period_cycles(CLK_HZ, SEL_4M));
    // Start on the last count so the first edge after reset opens a full period.
    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(period_cycles(CLK_HZ, DEFAULT_SEL) - 1);

    function automatic logic [CNT_W-1:0] period_of(input logic [2:0] sel);
        logic [CNT_W-1:0] p;
        case (sel)
            SEL_100K: p = PER_100K;
            SEL_200K: p = PER_200K;
            SEL_500K: p = PER_500K;
            SEL_1M:   p = PER_1M;
            SEL_2M:   p = PER_2M;
            default:  p = PER_4M;
        endcase
        return p;
    endfunction

    logic             filt_valid;
    logic [2:0]       filt_sel;

    state_e           state_q, state_d;
    logic [2:0]       active_q, active_d;
    logic [2:0]       pend_q, pend_d;
    logic             invalid_q, invalid_d;
    logic             defer_q, defer_d;
    logic [2:0]       defer_sel_q, defer_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    logic             ev_valid;
    logic [2:0]       ev_sel;
    logic             boundary;

    sel_filter #(
        .StableCycles (STABLE_CYCLES),
        .DefaultSel   (DEFAULT_SEL)
    ) u_sel_filter (
        .clk_i        (USER_CLOCK),
        .rst_ni       (RESET_N),
        .sel_i        (freq_io.FREQ_SEL),
        .filt_valid_o (filt_valid),
        .filt_sel_o   (filt_sel)
    );

    // An event that collides with the boundary is replayed on the next cycle.
    assign ev_valid = filt_valid | defer_q;
    assign ev_sel   = defer_q ? defer_sel_q : filt_sel;
    assign boundary = (cnt_q == period_of(active_q) - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pend_d      = pend_q;
        invalid_d   = invalid_q;
        defer_d     = 1'b0;
        defer_sel_d = defer_sel_q;

        case (state_q)
            StRun: begin
                if (ev_valid) begin
                    if (ev_sel > SEL_4M) begin
                        invalid_d = 1'b1;
                    end else begin
                        invalid_d = 1'b0;
                        if (ev_sel != active_q) begin
                            pend_d  = ev_sel;
                            state_d = StArmed;
                        end
                    end
                end
            end
            StArmed: begin
                if (boundary) begin
                    active_d = pend_q;
                    state_d  = StRun;
                    if (ev_valid) begin
                        defer_d     = 1'b1;
                        defer_sel_d = ev_sel;
                    end
                end else if (ev_valid) begin
                    if (ev_sel > SEL_4M) begin
                        invalid_d = 1'b1;
                    end else begin
                        invalid_d = 1'b0;
                        if (ev_sel == active_q) begin
                            state_d = StRun;
                        end else begin
                            pend_d = ev_sel;
                        end
                    end
                end
            end
            default: state_d = StRun;
        endcase

        cnt_d  = boundary ? '0 : cnt_q + CNT_W'(1);
        // Phase decision uses the period that the next count belongs to.
        out_d  = (cnt_d < (period_of(active_d) >> 1));
        tick_d = (cnt_d == '0);
    end

    always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StRun;
            active_q    <= DEFAULT_SEL;
            pend_q      <= DEFAULT_SEL;
            invalid_q   <= 1'b0;
            defer_q     <= 1'b0;
            defer_sel_q <= '0;
            cnt_q       <= CNT_RST;
            out_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            invalid_q   <= invalid_d;
            defer_q     <= defer_d;
            defer_sel_q <= defer_sel_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            tick_q      <= tick_d;
        end
    end

    assign freq_io.FREQ_OUT       = out_q;
    assign freq_io.FREQ_TICK      = tick_q;
    assign freq_io.FREQ_ACTIVE    = active_q;
    assign freq_io.CHANGE_PENDING = (state_q == StArmed);
    assign freq_io.SEL_INVALID    = invalid_q;

endmodule

// File: tb/tb_modclk_freq_select.sv
// Bench for modclk_freq_select: a period-level reference model issues select changes
// early in each modelled period and pushes the expected period record; a monitor pops
// one record per FREQ_TICK and checks timing, applied select, duty and status flags.
module tb_modclk_freq_select;

    localparam int unsigned ClkHz = 200_000_000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    modclk_freq_select_if bus ();

    modclk_freq_select #(
        .CLK_HZ        (ClkHz),
        .STABLE_CYCLES (16),
        .DEFAULT_SEL   (3'd5)
    ) dut (
        .USER_CLOCK (clk),
        .RESET_N    (rst_n),
        .freq_io    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned start;
        int unsigned sel;
        bit          inv;
        bit          pend;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc;

    // Rising edges since reset release; the first period starts at cyc == 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned period_of(input int unsigned sel);
        int unsigned hz;
        case (sel)
            0:       hz = 100_000;
            1:       hz = 200_000;
            2:       hz = 500_000;
            3:       hz = 1_000_000;
            4:       hz = 2_000_000;
            default: hz = 4_000_000;
        endcase
        return ClkHz / hz;
    endfunction

    // ---------------- monitor ----------------
    exp_t        m_cur, m_prev;
    bit          m_have_prev = 0;
    int unsigned m_high      = 0;
    bit          m_last_pend = 0;
    bit          m_last_inv  = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_have_prev = 0;
                m_high      = 0;
                m_last_pend = 0;
                m_last_inv  = 0;
            end else begin
                if (bus.FREQ_TICK) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_tick", 1, 0);
                    end else begin
                        m_cur = sbq.pop_front();
                        chk("tick_cycle", cyc, m_cur.start);
                        chk("freq_active", bus.FREQ_ACTIVE, m_cur.sel);
                        if (m_have_prev) begin
                            chk("high_phase", m_high, period_of(m_prev.sel) / 2);
                            chk("pending_at_end", m_last_pend, m_prev.pend);
                            chk("invalid_at_end", m_last_inv, m_prev.inv);
                        end
                        m_prev      = m_cur;
                        m_have_prev = 1;
                    end
                    m_high = 0;
                end
                m_high     += bus.FREQ_OUT;
                m_last_pend = bus.CHANGE_PENDING;
                m_last_inv  = bus.SEL_INVALID;
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    int unsigned s, act, pin, pend_sel;
    bit          inv, pend;

    task automatic wait_to(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Effect of one filtered select on the applied/pending/invalid state.
    task automatic model_event(input int unsigned v);
        if (v > 5) begin
            inv = 1;
        end else begin
            inv = 0;
            if (v == act) pend = 0;
            else begin
                pend     = 1;
                pend_sel = v;
            end
        end
    endtask

    task automatic push_period();
        exp_t e;
        e.start = s;
        e.sel   = act;
        e.inv   = inv;
        e.pend  = pend;
        sbq.push_back(e);
    endtask

    // typ: 0 idle, 1 set v1, 2 glitch to v1 for 10 cycles, 3 set v1 then v2 20 cycles later.
    // Called at cyc == s-1; returns at the last cycle of the modelled period.
    task automatic run_period(input int typ, input int unsigned v1, input int unsigned v2,
                              input int unsigned k);
        int unsigned p;
        p = period_of(act);
        case (typ)
            1: if (v1 != pin) model_event(v1);
            2: model_event(pin);
            3: begin
                if (v1 != pin) model_event(v1);
                if (v2 != v1) model_event(v2);
            end
            default: ;
        endcase
        push_period();
        wait_to(s + k);
        case (typ)
            1: begin
                bus.FREQ_SEL = 3'(v1);
                pin = v1;
            end
            2: begin
                bus.FREQ_SEL = 3'(v1);
                wait_to(s + k + 10);
                bus.FREQ_SEL = 3'(pin);
            end
            3: begin
                bus.FREQ_SEL = 3'(v1);
                wait_to(s + k + 20);
                bus.FREQ_SEL = 3'(v2);
                pin = v2;
            end
            default: ;
        endcase
        wait_to(s + p - 1);
        if (pend) begin
            act  = pend_sel;
            pend = 0;
        end
        s += p;
    endtask

    task automatic model_reset();
        act  = 5;
        pin  = 5;
        inv  = 0;
        pend = 0;
        s    = 1;
    endtask

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: time limit reached with %0d records queued", sbq.size());
        $fatal(1, "simulation did not complete");
    end

    initial begin : stimulus
        int typ;
        int unsigned v1, v2, k;
        bus.FREQ_SEL = 3'd5;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_freq_out", bus.FREQ_OUT, 0);
        chk("reset_freq_tick", bus.FREQ_TICK, 0);
        chk("reset_freq_active", bus.FREQ_ACTIVE, 5);
        chk("reset_change_pending", bus.CHANGE_PENDING, 0);
        chk("reset_sel_invalid", bus.SEL_INVALID, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        run_period(0, 0, 0, 0);   // default 4 MHz
        run_period(1, 0, 0, 3);   // 5 -> 0 mid-period
        run_period(0, 0, 0, 0);   // 2000-cycle period
        run_period(1, 5, 0, 1);   // back to 4 MHz
        run_period(2, 2, 0, 2);   // 10-cycle glitch to 2
        run_period(1, 7, 0, 4);   // invalid select
        run_period(0, 0, 0, 0);
        run_period(1, 3, 0, 0);   // valid select clears invalid
        run_period(0, 0, 0, 0);
        run_period(3, 0, 4, 5);   // armed for 0, overwritten by 4
        run_period(0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            typ = int'($urandom_range(0, 3));
            v1  = $urandom_range(0, 7);
            v2  = $urandom_range(0, 7);
            k   = $urandom_range(0, 8);
            if (typ == 2) v1 = (pin + $urandom_range(1, 7)) % 8;
            run_period(typ, v1, v2, k);
        end

        run_period(1, 3, 0, 0);   // ensure a 200-cycle period for the reset case

        // Arm for 0 at the period start, then reset mid-high-phase.
        push_period();
        wait_to(s);
        bus.FREQ_SEL = 3'd0;
        wait_to(s + 18);
        chk("pending_before_19", bus.CHANGE_PENDING, 0);
        wait_to(s + 19);
        chk("pending_at_19", bus.CHANGE_PENDING, 1);
        wait_to(s + 40);
        chk("pre_reset_freq_out", bus.FREQ_OUT, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_freq_out", bus.FREQ_OUT, 0);
        chk("async_reset_freq_active", bus.FREQ_ACTIVE, 5);
        chk("async_reset_change_pending", bus.CHANGE_PENDING, 0);
        chk("async_reset_freq_tick", bus.FREQ_TICK, 0);
        bus.FREQ_SEL = 3'd5;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        run_period(0, 0, 0, 0);
        run_period(0, 0, 0, 0);
        push_period();            // closes the last checked period
        wait_to(s + 1);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
